mesm6_acc_wb: RTL and testbench
===============================

Name: mesm6_acc_wb

Overview:
- Writeback stage directly downstream of the ALU.
- On a control-unit request it waits for the ALU `done` signal, then commits the ALU result into one of three registers: accumulator (ACC), low-order register (RMR), or mode register.
- On each commit it updates the omega condition flag used by conditional jumps.
- It handshakes with the microsequencer (req/ack) and bounds the wait for multicycle ALU operations with a timeout.

Parameters:
- TIMEOUT, 64, maximum cycles spent waiting for alu_done before aborting with an error (range 1..255).

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_r  in  48  ALU computed result.
- alu_done  in  1  ALU result valid this cycle.
- wr_req  in  1  single-cycle write request pulse from the control unit.
- wr_sel  in  2  destination: 00 ACC, 01 RMR, 10 SWAP (ACC <= alu_r, RMR <= old ACC), 11 MODE.
- grp_in  in  2  omega group for this write: 00 keep the current mode, 01 logical, 10 additive, 11 multiplicative.
- wr_ack  out  1  one-cycle pulse when the request completes (with or without error).
- wr_err  out  1  valid with wr_ack; 1 means timeout, no register written.
- busy  out  1  high while a request is outstanding (WAIT or ACK state).
- acc  out  48  accumulator.
- rmr  out  48  low-order register.
- mode  out  2  current omega group.
- omega  out  1  condition flag.

Behaviour:
- Reset values (asynchronous, whenever reset_n = 0):
  - acc = 0, rmr = 0, mode = 01, omega = 1.
  - wr_ack = 0, wr_err = 0, busy = 0, state IDLE, counter 0.
  - Reset mid-request aborts it silently; no ack is issued.
- All outputs are registered.
- FSM has states IDLE, WAIT, ACK.
- IDLE:
  - On wr_req = 1, latch wr_sel and grp_in.
  - If alu_done = 1 in the same cycle: commit alu_r at this edge and go to ACK.
  - Otherwise: clear the counter and go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If alu_done = 1: commit and go to ACK.
  - Else if counter reaches TIMEOUT-1: set wr_err, no commit, go to ACK.
  - If alu_done arrives on the timeout cycle, alu_done wins (commit, no error).
- ACK:
  - wr_ack = 1 for exactly one cycle, then return to IDLE.
  - wr_err clears when returning to IDLE.
- busy = 1 in WAIT and ACK.
- wr_req is ignored outside IDLE; there is no queuing.
- Minimum latency: request with done in the same cycle gives wr_ack in the following cycle.
- Commit actions:
  - ACC: acc <= alu_r.
  - RMR: rmr <= alu_r.
  - SWAP: acc <= alu_r and rmr <= pre-commit acc, both at the same edge.
  - MODE: mode <= alu_r[1:0]; if alu_r[1:0] = 00, mode is unchanged.
- Mode update on ACC/SWAP commits: if latched grp_in != 00, mode <= grp_in. RMR commits never change mode or omega.
- Omega is recomputed at the commit edge from the new acc and new mode:
  - logical (01): omega = (acc == 0).
  - additive (10): omega = acc[40] (mantissa sign).
  - multiplicative (11): omega = acc[47].
  - A MODE commit recomputes omega from the unchanged acc under the new mode.
- No arithmetic is performed here; widths pass through unchanged.

Test Plan:
- Reset release → acc = 0, rmr = 0, mode = 01, omega = 1, busy = 0, wr_ack = 0.
- wr_req with wr_sel = 00, grp_in = 10, alu_r = 48'h010000000000, alu_done = 1 in the same cycle → next cycle wr_ack = 1, wr_err = 0, acc = 48'h010000000000, mode = 10, omega = 1.
- acc = 48'h5, wr_req SWAP, alu_done asserted 3 cycles later with alu_r = 48'h7 → busy for 4 cycles, then wr_ack; acc = 7, rmr = 5, omega reflects acc = 7 under the current mode.
- TIMEOUT = 4, wr_req with alu_done held low → wr_ack with wr_err = 1 on the 5th cycle after the request; acc, rmr, mode, omega unchanged. A second wr_req during WAIT is ignored.
- acc = 0, MODE write alu_r[1:0] = 11 → mode = 11, omega = 0. Then MODE write with alu_r[1:0] = 00 → mode stays 11.
- reset_n pulsed low during WAIT → immediate reset values, no wr_ack. A fresh request after release completes normally.

Source files
------------

// File: rtl/mesm6_acc_wb.sv
// Writeback stage after the ALU: waits for alu_done, commits the result to ACC/RMR/MODE
// and recomputes the omega condition flag; bounded wait with timeout error.
module mesm6_acc_wb #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [47:0] alu_r,
    input  logic        alu_done,
    input  logic        wr_req,
    input  logic [1:0]  wr_sel,
    input  logic [1:0]  grp_in,
    output logic        wr_ack,
    output logic        wr_err,
    output logic        busy,
    output logic [47:0] acc,
    output logic [47:0] rmr,
    output logic [1:0]  mode,
    output logic        omega
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    localparam logic [1:0] SEL_ACC  = 2'b00;
    localparam logic [1:0] SEL_RMR  = 2'b01;
    localparam logic [1:0] SEL_SWAP = 2'b10;
    localparam logic [1:0] SEL_MODE = 2'b11;

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  grp_q, grp_d;
    logic [47:0] acc_q, acc_d;
    logic [47:0] rmr_q, rmr_d;
    logic [1:0]  mode_q, mode_d;
    logic        omega_q, omega_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;

    logic        commit;
    logic [1:0]  eff_sel;
    logic [1:0]  eff_grp;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grp_d   = grp_q;
        acc_d   = acc_q;
        rmr_d   = rmr_q;
        mode_d  = mode_q;
        omega_d = omega_q;
        err_d   = err_q;
        commit  = 1'b0;
        eff_sel = sel_q;
        eff_grp = grp_q;

        case (state_q)
            S_IDLE: begin
                if (wr_req) begin
                    sel_d   = wr_sel;
                    grp_d   = grp_in;
                    // Same-cycle commit must use the live request fields, not the latched copy
                    eff_sel = wr_sel;
                    eff_grp = grp_in;
                    if (alu_done) begin
                        commit  = 1'b1;
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (alu_done) begin
                    commit  = 1'b1;
                    state_d = S_ACK;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_ACK: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (commit) begin
            case (eff_sel)
                SEL_ACC: begin
                    acc_d = alu_r;
                    if (eff_grp != 2'b00) mode_d = eff_grp;
                end
                SEL_RMR: begin
                    rmr_d = alu_r;
                end
                SEL_SWAP: begin
                    acc_d = alu_r;
                    rmr_d = acc_q;
                    if (eff_grp != 2'b00) mode_d = eff_grp;
                end
                SEL_MODE: begin
                    if (alu_r[1:0] != 2'b00) mode_d = alu_r[1:0];
                end
                default: ;
            endcase

            if (eff_sel != SEL_RMR) begin
                case (mode_d)
                    2'b01:   omega_d = (acc_d == '0);
                    2'b10:   omega_d = acc_d[40];
                    2'b11:   omega_d = acc_d[47];
                    default: omega_d = omega_q;
                endcase
            end
        end

        ack_d  = (state_d == S_ACK);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sel_q   <= '0;
            grp_q   <= '0;
            acc_q   <= '0;
            rmr_q   <= '0;
            mode_q  <= 2'b01;
            omega_q <= 1'b1;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grp_q   <= grp_d;
            acc_q   <= acc_d;
            rmr_q   <= rmr_d;
            mode_q  <= mode_d;
            omega_q <= omega_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
        end
    end

    assign wr_ack = ack_q;
    assign wr_err = err_q;
    assign busy   = busy_q;
    assign acc    = acc_q;
    assign rmr    = rmr_q;
    assign mode   = mode_q;
    assign omega  = omega_q;

endmodule

// File: tb/tb_mesm6_acc_wb.sv
// Scoreboard bench for mesm6_acc_wb: a request-level model predicts each ack's cycle
// and resulting register state; a monitor pops and compares on every wr_ack.
module tb_mesm6_acc_wb;

    localparam int unsigned TO = 4;

    logic        clk;
    logic        reset_n;
    logic [47:0] alu_r;
    logic        alu_done;
    logic        wr_req;
    logic [1:0]  wr_sel;
    logic [1:0]  grp_in;
    logic        wr_ack;
    logic        wr_err;
    logic        busy;
    logic [47:0] acc;
    logic [47:0] rmr;
    logic [1:0]  mode;
    logic        omega;

    mesm6_acc_wb #(.TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .alu_r    (alu_r),
        .alu_done (alu_done),
        .wr_req   (wr_req),
        .wr_sel   (wr_sel),
        .grp_in   (grp_in),
        .wr_ack   (wr_ack),
        .wr_err   (wr_err),
        .busy     (busy),
        .acc      (acc),
        .rmr      (rmr),
        .mode     (mode),
        .omega    (omega)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          ack_cyc;
        logic        err;
        logic [47:0] acc;
        logic [47:0] rmr;
        logic [1:0]  mode;
        logic        omega;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    // Architectural reference state
    logic [47:0] m_acc;
    logic [47:0] m_rmr;
    logic [1:0]  m_mode;
    logic        m_omega;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic omega_of(input logic [47:0] a, input logic [1:0] m);
        if (m == 2'b01) return (a == 48'd0);
        if (m == 2'b10) return a[40];
        return a[47];
    endfunction

    task automatic model_reset();
        m_acc   = '0;
        m_rmr   = '0;
        m_mode  = 2'b01;
        m_omega = 1'b1;
    endtask

    task automatic model_commit(input logic [1:0] sel, input logic [1:0] grp, input logic [47:0] r);
        logic [47:0] old_acc;
        old_acc = m_acc;
        if (sel == 2'b01) begin
            m_rmr = r;
            return;
        end
        if (sel == 2'b00 || sel == 2'b10) begin
            m_acc = r;
            if (sel == 2'b10) m_rmr = old_acc;
            if (grp != 2'b00) m_mode = grp;
        end else if (r[1:0] != 2'b00) begin
            m_mode = r[1:0];
        end
        m_omega = omega_of(m_acc, m_mode);
    endtask

    // Monitor: every wr_ack must match the oldest outstanding prediction
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (wr_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 48'd1, 48'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("ack_cycle", 48'(cyc), 48'(e.ack_cyc));
                    check("wr_err", {47'd0, wr_err}, {47'd0, e.err});
                    check("acc", acc, e.acc);
                    check("rmr", rmr, e.rmr);
                    check("mode", {46'd0, mode}, {46'd0, e.mode});
                    check("omega", {47'd0, omega}, {47'd0, e.omega});
                end
            end
        end
    end

    function automatic logic [47:0] rnd48();
        return {16'($urandom), $urandom};
    endfunction

    // d = cycles after the request edge at which alu_done is presented (0 = same cycle);
    // d > TO means alu_done never comes and the request must time out.
    task automatic do_req(input logic [1:0] sel, input logic [1:0] grp, input logic [47:0] r,
                          input int d, input bit spur);
        exp_t e;
        int   dd;
        dd = (d <= int'(TO)) ? d : int'(TO);
        wr_req   = 1'b1;
        wr_sel   = sel;
        grp_in   = grp;
        alu_done = (d == 0);
        alu_r    = (d == 0) ? r : rnd48();
        if (d <= int'(TO)) model_commit(sel, grp, r);
        e.ack_cyc = cyc + 1 + dd;
        e.err     = (d > int'(TO));
        e.acc     = m_acc;
        e.rmr     = m_rmr;
        e.mode    = m_mode;
        e.omega   = m_omega;
        exp_q.push_back(e);
        for (int k = 1; k <= dd; k++) begin
            @(negedge clk);
            check("busy_wait", {47'd0, busy}, 48'd1);
            wr_req   = spur ? 1'($urandom) : 1'b0;
            wr_sel   = 2'($urandom);
            grp_in   = 2'($urandom);
            alu_done = (k == d);
            alu_r    = (k == d) ? r : rnd48();
        end
        @(negedge clk);
        check("busy_ack", {47'd0, busy}, 48'd1);
        wr_req   = 1'b0;
        alu_done = 1'b0;
        @(negedge clk);
        check("ack_seen", 48'(exp_q.size()), 48'd0);
        check("busy_idle", {47'd0, busy}, 48'd0);
        check("err_clear", {47'd0, wr_err}, 48'd0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_acc"}, acc, 48'd0);
        check({tag, "_rmr"}, rmr, 48'd0);
        check({tag, "_mode"}, {46'd0, mode}, 48'd1);
        check({tag, "_omega"}, {47'd0, omega}, 48'd1);
        check({tag, "_busy"}, {47'd0, busy}, 48'd0);
        check({tag, "_ack"}, {47'd0, wr_ack}, 48'd0);
        check({tag, "_err"}, {47'd0, wr_err}, 48'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        alu_r    = '0;
        alu_done = 1'b0;
        wr_req   = 1'b0;
        wr_sel   = '0;
        grp_in   = '0;
        model_reset();
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_state("rst");

        do_req(2'b00, 2'b10, 48'h010000000000, 0, 1'b0);
        do_req(2'b00, 2'b00, 48'h5, 0, 1'b0);
        do_req(2'b10, 2'b00, 48'h7, 3, 1'b0);
        do_req(2'b01, 2'b11, 48'h123456789abc, TO + 3, 1'b1);
        do_req(2'b00, 2'b01, 48'h0, 1, 1'b0);
        do_req(2'b11, 2'b00, 48'hfffffffffff3, 2, 1'b0);
        do_req(2'b11, 2'b10, 48'hfffffffffff0, 0, 1'b0);
        do_req(2'b10, 2'b11, 48'h800000000000, TO, 1'b1);

        for (int i = 0; i < 80; i++) begin
            logic [47:0] r;
            r = rnd48();
            case ($urandom_range(0, 3))
                0: r = '0;
                1: r[40] = ~r[40];
                default: ;
            endcase
            do_req(2'($urandom), 2'($urandom), r, $urandom_range(0, TO + 2), 1'b1);
        end

        // Reset in the middle of a wait aborts the request without an ack
        wr_req   = 1'b1;
        wr_sel   = 2'b00;
        grp_in   = 2'b11;
        alu_done = 1'b0;
        alu_r    = rnd48();
        @(negedge clk);
        wr_req = 1'b0;
        check("busy_pre_rst", {47'd0, busy}, 48'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("midrst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        repeat (TO + 2) begin
            @(negedge clk);
            check("no_ack_after_rst", {47'd0, wr_ack}, 48'd0);
        end
        do_req(2'b10, 2'b10, 48'h0000ffff0000, 2, 1'b0);
        do_req(2'b01, 2'b00, 48'h0000000000aa, 0, 1'b0);

        check("queue_empty", 48'(exp_q.size()), 48'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
